alu_operand_loader: RTL and testbench
=====================================

Name: alu_operand_loader

Overview:
Sequential front-end that sits directly upstream of the 16-bit ALU. It captures operand A, operand B and the opcode one after another from a shared switch bus, each on an "enter" button edge. It then presents all three to the ALU together, with a valid flag.
It replaces the static stimulus currently driving the ALU, so the lab board can drive the ALU interactively. Stage indication goes out to LEDs.

Parameters:
WIDTH, 16, operand width; matches ALU A/B inputs.
OP_WIDTH, 2, opcode width; taken from data_in[OP_WIDTH-1:0].
CNT_WIDTH, 8, width of completed-load counter.

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous, active-low reset.
data_in  input  WIDTH  switch bus; shared by A, B and OP entry.
enter  input  1  debounced button level; advances on rising edge.
undo  input  1  debounced button level; steps back on rising edge.
a_out  output  WIDTH  registered operand A; drives ALU A.
b_out  output  WIDTH  registered operand B; drives ALU B.
op_out  output  OP_WIDTH  registered opcode; drives ALU OP (zero-extended at ALU if wider).
operands_valid  output  1  high only in state SHOW.
stage  output  2  current state encoding for LEDs.
load_count  output  CNT_WIDTH  number of completed A/B/OP sequences; wraps.

Behaviour:
- Reset (async assert, sync-released by clk): state=WAIT_A; a_out=0, b_out=0, op_out=0, operands_valid=0, stage=0, load_count=0. Edge-detect registers enter_q=1, undo_q=1, so a button held through reset produces no edge until released and re-pressed.
- Edge detect: enter_rise = enter & ~enter_q; undo_rise = undo & ~undo_q. enter_q and undo_q are registered every cycle.
- States and encodings: WAIT_A=0, WAIT_B=1, WAIT_OP=2, SHOW=3. stage = state encoding.
- enter_rise transitions:
  - WAIT_A: a_out<=data_in, go to WAIT_B.
  - WAIT_B: b_out<=data_in, go to WAIT_OP.
  - WAIT_OP: op_out<=data_in[OP_WIDTH-1:0], go to SHOW, load_count<=load_count+1 (wraps 2^CNT_WIDTH-1 -> 0).
  - SHOW: go to WAIT_A; registers unchanged.
- undo_rise transitions: WAIT_B->WAIT_A, WAIT_OP->WAIT_B, SHOW->WAIT_OP, WAIT_A stays. Data registers and load_count are never modified by undo. Re-entering a stage overwrites only that stage's register.
- Simultaneous enter_rise and undo_rise in the same cycle: undo wins, enter ignored.
- Latency: an edge sampled at clock edge N updates registers and state at edge N; outputs are visible in cycle N+1. operands_valid asserts the cycle after the OP capture edge.
- operands_valid is combinational from state (state==SHOW); all other outputs come directly from flops.
- data_in changes outside capture edges have no effect.
- Reset mid-sequence: immediate return to reset values, including a_out/b_out/op_out; no partial state survives.

Decomposition:
- Package alu_loader_pkg:
  - typedef enum logic [1:0] loader_state_t {WAIT_A, WAIT_B, WAIT_OP, SHOW}.
  - localparam defaults for WIDTH/OP_WIDTH.
- Sub-module rise_detect: parameterless 1-bit edge detector with reset value 1. Instantiated twice (enter, undo).
- FSM and capture registers live in alu_operand_loader.

Test Plan:
- Reset with enter held high, release reset, keep enter high 5 cycles -> stage stays 0, a_out=0; drop and re-raise enter with data_in=16'h0001 -> a_out=16'h0001, stage=1.
- Full sequence: data_in 16'h1234 enter, 16'h00FF enter, 16'h0002 enter -> a_out=16'h1234, b_out=16'h00FF, op_out=2'b10, operands_valid=1 one cycle after third capture edge, load_count=1.
- Undo: after A=16'h0005 and B=16'h0007, undo then enter with 16'h0009 -> b_out=16'h0009, a_out=16'h0005, stage=2.
- Simultaneous enter and undo rise in WAIT_OP -> stage=1, op_out unchanged, load_count unchanged.
- Counter wrap: complete 256 sequences -> load_count returns to 0; enter in SHOW -> stage=0, operands_valid=0, registers retained.
- Async reset asserted mid-cycle in WAIT_OP -> all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/alu_loader_pkg.sv
// -----------------------------------------------------------------------------
// alu_loader_pkg
// Shared types and defaults for the ALU operand loader.
//   loader_state_t : entry stage, encoding doubles as the LED stage code
//   DEF_*          : default widths (ALU operand, opcode, load counter)
//   undo_target()  : state reached when the user steps back one stage
// -----------------------------------------------------------------------------
package alu_loader_pkg;

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        SHOW    = 2'd3
    } loader_state_t;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_OP_WIDTH  = 2;
    localparam int DEF_CNT_WIDTH = 8;

    // Stepping back from WAIT_A has nowhere to go, so it stays put.
    function automatic loader_state_t undo_target(input loader_state_t cur);
        loader_state_t nxt;
        case (cur)
            WAIT_A:  nxt = WAIT_A;
            WAIT_B:  nxt = WAIT_A;
            WAIT_OP: nxt = WAIT_B;
            SHOW:    nxt = WAIT_OP;
            default: nxt = WAIT_A;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/alu_operand_loader_rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// One-bit rising-edge detector for a debounced button level.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   i_d   : button level
//   o_rise: high for the cycle in which i_d is 1 and was 0 last cycle
// The history flop resets to 1 so that a button held through reset does not
// register as a press until it is released and pressed again.
// -----------------------------------------------------------------------------
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    // Previous-cycle copy of the button level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b1;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/alu_operand_loader.sv
// -----------------------------------------------------------------------------
// alu_operand_loader
// Captures operand A, operand B and the opcode from a shared switch bus on
// successive "enter" presses, then presents them together to the ALU.
//   clk            : system clock
//   reset_n        : asynchronous active-low reset (release synchronised here)
//   data_in        : switch bus shared by A, B and OP entry
//   enter / undo   : debounced button levels, act on rising edge
//   a_out / b_out  : captured operands (registered)
//   op_out         : captured opcode, data_in[OP_WIDTH-1:0] (registered)
//   operands_valid : high while the full operand set is shown
//   stage          : current state encoding for the LEDs
//   load_count     : completed A/B/OP sequences, wraps
// -----------------------------------------------------------------------------
module alu_operand_loader
    import alu_loader_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int OP_WIDTH  = DEF_OP_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 enter,
    input  logic                 undo,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    output logic [OP_WIDTH-1:0]  op_out,
    output logic                 operands_valid,
    output logic [1:0]           stage,
    output logic [CNT_WIDTH-1:0] load_count
);

    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    logic                 w_enter_rise;
    logic                 w_undo_rise;
    loader_state_t        r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [OP_WIDTH-1:0]  r_op;
    logic [CNT_WIDTH-1:0] r_cnt;

    // Reset synchroniser: assertion takes effect at once, release waits two clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    rise_detect u_enter_rise (
        .clk    (clk),
        .rst_n  (w_rst_n),
        .i_d    (enter),
        .o_rise (w_enter_rise)
    );

    rise_detect u_undo_rise (
        .clk    (clk),
        .rst_n  (w_rst_n),
        .i_d    (undo),
        .o_rise (w_undo_rise)
    );

    // Entry FSM with capture registers; undo takes priority over enter.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= WAIT_A;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
        end else if (w_undo_rise) begin
            r_state <= undo_target(r_state);
        end else if (w_enter_rise) begin
            case (r_state)
                WAIT_A: begin
                    r_a     <= data_in;
                    r_state <= WAIT_B;
                end
                WAIT_B: begin
                    r_b     <= data_in;
                    r_state <= WAIT_OP;
                end
                WAIT_OP: begin
                    r_op    <= data_in[OP_WIDTH-1:0];
                    r_cnt   <= r_cnt + CNT_WIDTH'(1);
                    r_state <= SHOW;
                end
                SHOW: begin
                    r_state <= WAIT_A;
                end
                default: begin
                    r_state <= WAIT_A;
                end
            endcase
        end else begin
            r_state <= r_state;
        end
    end

    assign a_out          = r_a;
    assign b_out          = r_b;
    assign op_out         = r_op;
    assign load_count     = r_cnt;
    assign stage          = r_state;
    assign operands_valid = (r_state == SHOW);

endmodule

// File: tb/tb_alu_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_loader
// Directed bench with a reference model feeding a scoreboard queue: every
// driven cycle pushes the expected outputs, which are popped and compared
// one cycle later, after the active clock edge.
// -----------------------------------------------------------------------------
module tb_alu_operand_loader;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic        valid;
        logic [1:0]  stage;
        logic [7:0]  cnt;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [15:0] data_in;
    logic        enter;
    logic        undo;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic [1:0]  op_out;
    logic        operands_valid;
    logic [1:0]  stage;
    logic [7:0]  load_count;

    int checks   = 0;
    int failures = 0;
    exp_t sb_q[$];

    // Reference model state
    int          m_state;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [1:0]  m_op;
    logic [7:0]  m_cnt;
    logic        m_eq;
    logic        m_uq;

    alu_operand_loader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .data_in        (data_in),
        .enter          (enter),
        .undo           (undo),
        .a_out          (a_out),
        .b_out          (b_out),
        .op_out         (op_out),
        .operands_valid (operands_valid),
        .stage          (stage),
        .load_count     (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_a = 16'h0000;
        m_b = 16'h0000;
        m_op = 2'b00;
        m_cnt = 8'h00;
        m_eq = 1'b1;
        m_uq = 1'b1;
    endtask

    task automatic model_step(input logic e, input logic u, input logic [15:0] d);
        logic er;
        logic ur;
        er = e & ~m_eq;
        ur = u & ~m_uq;
        m_eq = e;
        m_uq = u;
        if (ur) begin
            if (m_state != 0) m_state = m_state - 1;
        end else if (er) begin
            case (m_state)
                0: begin m_a = d; m_state = 1; end
                1: begin m_b = d; m_state = 2; end
                2: begin m_op = d[1:0]; m_cnt = m_cnt + 8'd1; m_state = 3; end
                default: m_state = 0;
            endcase
        end
    endtask

    // Drive one cycle of inputs, predict, then compare after the clock edge.
    task automatic drive(input logic e, input logic u, input logic [15:0] d);
        exp_t ex;
        @(negedge clk);
        enter = e;
        undo = u;
        data_in = d;
        model_step(e, u, d);
        ex.a = m_a;
        ex.b = m_b;
        ex.op = m_op;
        ex.valid = (m_state == 3);
        ex.stage = 2'(m_state);
        ex.cnt = m_cnt;
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        checks++;
        assert (sb_q.size() > 0) else begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb_q.size() > 0) begin
            ex = sb_q.pop_front();
            chk("a_out", 32'(a_out), 32'(ex.a));
            chk("b_out", 32'(b_out), 32'(ex.b));
            chk("op_out", 32'(op_out), 32'(ex.op));
            chk("operands_valid", 32'(operands_valid), 32'(ex.valid));
            chk("stage", 32'(stage), 32'(ex.stage));
            chk("load_count", 32'(load_count), 32'(ex.cnt));
        end
    endtask

    task automatic press(input logic [15:0] d);
        drive(1'b1, 1'b0, d);
        drive(1'b0, 1'b0, d);
    endtask

    initial begin
        reset_n = 1'b0;
        enter = 1'b1;
        undo = 1'b0;
        data_in = 16'h0000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", 32'(a_out), 32'h0);
        chk("reset_stage", 32'(stage), 32'h0);
        chk("reset_valid", 32'(operands_valid), 32'h0);
        chk("reset_count", 32'(load_count), 32'h0);

        // Enter held through reset release: no capture.
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) drive(1'b1, 1'b0, 16'hBEEF);
        chk("held_enter_stage", 32'(stage), 32'h0);
        drive(1'b0, 1'b0, 16'h0001);
        press(16'h0001);
        chk("first_a", 32'(a_out), 32'h0001);
        chk("first_stage", 32'(stage), 32'h1);

        // Back to WAIT_A, then a full sequence.
        drive(1'b0, 1'b1, 16'h0000);
        drive(1'b0, 1'b0, 16'h0000);
        press(16'h1234);
        press(16'h00FF);
        drive(1'b1, 1'b0, 16'h0002);
        chk("seq_valid", 32'(operands_valid), 32'h1);
        chk("seq_op", 32'(op_out), 32'h2);
        chk("seq_a", 32'(a_out), 32'h1234);
        chk("seq_b", 32'(b_out), 32'h00FF);
        chk("seq_count", 32'(load_count), 32'h1);
        drive(1'b0, 1'b0, 16'hAAAA);
        press(16'h5555);
        chk("show_exit_stage", 32'(stage), 32'h0);

        // Undo then re-enter B.
        press(16'h0005);
        press(16'h0007);
        drive(1'b0, 1'b1, 16'h0007);
        drive(1'b0, 1'b0, 16'h0007);
        chk("undo_stage", 32'(stage), 32'h1);
        press(16'h0009);
        chk("undo_b", 32'(b_out), 32'h0009);
        chk("undo_a", 32'(a_out), 32'h0005);
        chk("undo_reenter_stage", 32'(stage), 32'h2);

        // Simultaneous enter and undo in WAIT_OP: undo wins.
        drive(1'b1, 1'b1, 16'h0001);
        drive(1'b0, 1'b0, 16'h0001);
        chk("simul_stage", 32'(stage), 32'h1);
        chk("simul_op", 32'(op_out), 32'h2);
        chk("simul_count", 32'(load_count), 32'h1);
        press(16'h0011);
        press(16'h0003);
        press(16'h0000);

        // Counter wrap.
        while (m_cnt != 8'hFF) begin
            press(16'(m_cnt));
            press(16'(~m_cnt));
            press(16'(m_cnt + 8'd1));
            press(16'h0000);
        end
        press(16'h0123);
        press(16'h0456);
        press(16'h0001);
        chk("wrap_count", 32'(load_count), 32'h0);
        chk("wrap_valid", 32'(operands_valid), 32'h1);
        press(16'hFFFF);
        chk("wrap_exit_stage", 32'(stage), 32'h0);
        chk("wrap_exit_valid", 32'(operands_valid), 32'h0);
        chk("wrap_retain_a", 32'(a_out), 32'h0123);
        chk("wrap_retain_op", 32'(op_out), 32'h1);

        // Asynchronous reset mid-cycle in WAIT_OP.
        press(16'h7777);
        press(16'h8888);
        chk("pre_reset_stage", 32'(stage), 32'h2);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_a", 32'(a_out), 32'h0);
        chk("async_b", 32'(b_out), 32'h0);
        chk("async_op", 32'(op_out), 32'h0);
        chk("async_stage", 32'(stage), 32'h0);
        chk("async_valid", 32'(operands_valid), 32'h0);
        chk("async_count", 32'(load_count), 32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) drive(1'b0, 1'b0, 16'h0000);
        press(16'h4321);
        chk("post_reset_a", 32'(a_out), 32'h4321);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
